riscv_mem_arb: RTL and testbench
================================

RISCV_MEM_ARB -- requirements
Module: riscv_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of all address ports.
REQ-002 SHALL have parameter MAX_STARVE, default 4: consecutive fetch denials before fetch is forced to win; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port x_reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port if_req  input  1  instruction-fetch request, held until granted.
REQ-006 SHALL have port if_addr  input  ADDR_W  fetch address.
REQ-007 SHALL have port if_gnt  output  1  fetch granted this cycle.
REQ-008 SHALL have port if_rvalid  output  1  fetch data valid.
REQ-009 SHALL have port if_rdata  output  32  fetch data.
REQ-010 SHALL have port d_req  input  1  load/store request, held until granted.
REQ-011 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port d_addr  input  ADDR_W  data address.
REQ-013 SHALL have port d_wdata  input  32  store data, pre-masked by the requester.
REQ-014 SHALL have port d_gnt  output  1  data access granted this cycle.
REQ-015 SHALL have port d_rvalid  output  1  load data valid.
REQ-016 SHALL have port d_rdata  output  32  load data.
REQ-017 SHALL have port mem_en  output  1  single-port RAM access strobe.
REQ-018 SHALL have port mem_we  output  1  RAM write enable.
REQ-019 SHALL have port mem_addr  output  ADDR_W  RAM address.
REQ-020 SHALL have port mem_wdata  output  32  RAM write data.
REQ-021 SHALL have port mem_rdata  input  32  RAM read data, valid one cycle after the read strobe.
REQ-022 SHALL have port if_stall  output  1  high when if_req is high and if_gnt is low, for pc hold.

Function
REQ-023 SHALL grant at most one requester per cycle; grant is combinational from the current requests and registered state.
REQ-024 SHALL grant d_req over if_req (default priority) unless the starvation counter equals MAX_STARVE, in which case if_req wins.
REQ-025 SHALL increment a 4-bit starvation counter in each cycle where if_req=1 and if_gnt=0, and clear it on any if_gnt; the counter saturates at MAX_STARVE.
REQ-026 SHALL drive mem_en=1 and route the winner's address and data onto mem_* in the grant cycle; mem_we=d_we&d_gnt; mem_* are zero when no grant.
REQ-027 SHALL register the read owner (NONE/IF/D) at grant; in the next cycle it pulses the owner's rvalid with rdata=mem_rdata. Read latency is exactly 1 cycle.
REQ-028 SHALL NOT produce d_rvalid for stores; a store completes in its grant cycle.
REQ-029 SHALL allow back-to-back grants every cycle; a response for grant N and the grant for N+1 coexist in the same cycle.
REQ-030 SHALL hold if_rdata and d_rdata at their last value when the matching rvalid is low.
REQ-031 SHALL, when both requests are high and neither starvation nor the round-robin rule applies, grant data and assert if_stall.

Reset
REQ-032 SHALL, when x_reset=1 at a clock edge, clear the owner to NONE, the starvation counter to 0 and the round-robin pointer to data-first; all outputs are 0 in the following cycle.
REQ-033 SHALL discard any response pending when reset is asserted mid-access; no rvalid appears after reset.
REQ-034 SHALL suppress all grants and mem_en while x_reset=1.

Configuration
REQ-035 SHALL support macro RISCV_MEM_ARB_RR_EN: when defined, simultaneous requests alternate via a 1-bit pointer that flips to the loser after each contended grant, and the starvation counter is not instantiated; when undefined, the fixed-priority and starvation behaviour of REQ-024/025 applies.

Verification
REQ-036 SHALL verify fetch only: if_req=1, if_addr=0x100 and mem_rdata=0x00000013 on the next cycle -> if_gnt same cycle, if_rvalid=1 and if_rdata=0x13 exactly one cycle later.
REQ-037 SHALL verify contention: if_req=d_req=1 with load d_addr=0x200 -> d_gnt=1, if_stall=1, mem_addr=0x200, d_rvalid the next cycle; fetch granted when d_req drops.
REQ-038 SHALL verify starvation with MAX_STARVE=4 and both requests held: four d_gnt cycles, then if_gnt on the fifth cycle, counter returns to 0.
REQ-039 SHALL verify store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF in the grant cycle, no d_rvalid afterwards.
REQ-040 SHALL verify reset mid-read: x_reset=1 in the cycle after a fetch grant -> if_rvalid stays 0 and all outputs are 0.
REQ-041 SHALL verify, with RISCV_MEM_ARB_RR_EN defined and both requests held, that grants alternate D, IF, D, IF.

Source files
------------

// File: rtl/riscv_mem_arb_if.sv
// Bundle of fetch, load/store and single-port RAM signals seen by riscv_mem_arb.
// The arbiter binds the slave modport; requesters and the RAM drive the master side.
interface riscv_mem_arb_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              if_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_stall, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_stall, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/riscv_mem_arb.sv
// Fetch vs load/store arbiter in front of a single-port RAM with 1-cycle read latency.
// Define RISCV_MEM_ARB_RR_EN for round-robin contention instead of data-priority + starvation.
module riscv_mem_arb #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MAX_STARVE = 4
) (
    input logic             clk,
    input logic             x_reset,
    riscv_mem_arb_if.slave  bus
);

    typedef enum logic [1:0] {OwnNone, OwnIf, OwnD} owner_e;

    owner_e      owner_q, owner_d;
    logic [31:0] if_hold_q, if_hold_d;
    logic [31:0] d_hold_q, d_hold_d;
    logic        if_gnt, d_gnt;
    logic        contended;

`ifdef RISCV_MEM_ARB_RR_EN
    // 1 = fetch wins the next contended cycle.
    logic ptr_q, ptr_d;
`else
    localparam logic [3:0] StarveMax = MAX_STARVE[3:0];
    logic [3:0] starve_q, starve_d;
`endif

    assign contended = bus.if_req && bus.d_req;

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!x_reset) begin
            if (contended) begin
`ifdef RISCV_MEM_ARB_RR_EN
                if (ptr_q) begin
                    if_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
`else
                if (starve_q == StarveMax) begin
                    if_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
`endif
            end else begin
                if_gnt = bus.if_req;
                d_gnt  = bus.d_req;
            end
        end
    end

    always_comb begin
        if (if_gnt) begin
            owner_d = OwnIf;
        end else if (d_gnt && !bus.d_we) begin
            owner_d = OwnD;
        end else begin
            owner_d = OwnNone;
        end
        if_hold_d = (owner_q == OwnIf) ? bus.mem_rdata : if_hold_q;
        d_hold_d  = (owner_q == OwnD) ? bus.mem_rdata : d_hold_q;
`ifdef RISCV_MEM_ARB_RR_EN
        ptr_d = ptr_q;
        // Hand priority to whoever just lost.
        if (contended && !x_reset) begin
            ptr_d = d_gnt;
        end
`else
        starve_d = starve_q;
        if (if_gnt) begin
            starve_d = 4'd0;
        end else if (bus.if_req && starve_q != StarveMax) begin
            starve_d = starve_q + 4'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (x_reset) begin
            owner_q   <= OwnNone;
            if_hold_q <= 32'd0;
            d_hold_q  <= 32'd0;
`ifdef RISCV_MEM_ARB_RR_EN
            ptr_q     <= 1'b0;
`else
            starve_q  <= 4'd0;
`endif
        end else begin
            owner_q   <= owner_d;
            if_hold_q <= if_hold_d;
            d_hold_q  <= d_hold_d;
`ifdef RISCV_MEM_ARB_RR_EN
            ptr_q     <= ptr_d;
`else
            starve_q  <= starve_d;
`endif
        end
    end

    // Responses are masked while reset is high so a discarded read never surfaces.
    always_comb begin
        bus.if_gnt    = if_gnt;
        bus.d_gnt     = d_gnt;
        bus.if_stall  = !x_reset && bus.if_req && !if_gnt;
        bus.mem_en    = if_gnt || d_gnt;
        bus.mem_we    = d_gnt && bus.d_we;
        bus.mem_addr  = {ADDR_W{1'b0}};
        bus.mem_wdata = 32'd0;
        if (if_gnt) begin
            bus.mem_addr = bus.if_addr;
        end else if (d_gnt) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end
        bus.if_rvalid = !x_reset && (owner_q == OwnIf);
        bus.d_rvalid  = !x_reset && (owner_q == OwnD);
        bus.if_rdata  = 32'd0;
        bus.d_rdata   = 32'd0;
        if (!x_reset) begin
            bus.if_rdata = (owner_q == OwnIf) ? bus.mem_rdata : if_hold_q;
            bus.d_rdata  = (owner_q == OwnD) ? bus.mem_rdata : d_hold_q;
        end
    end

endmodule

// File: tb/tb_riscv_mem_arb.sv
// Directed + random bench for riscv_mem_arb against a cycle-level reference model.
module tb_riscv_mem_arb;
    localparam int unsigned AW = 32;
    localparam int MS = 4;

    logic clk = 1'b0;
    logic x_reset;
    always #5 clk = ~clk;

    riscv_mem_arb_if #(.ADDR_W(AW)) bus ();

    riscv_mem_arb #(.ADDR_W(AW), .MAX_STARVE(MS)) dut (
        .clk     (clk),
        .x_reset (x_reset),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: RAM contents, starvation count, contention pointer, pending read.
    logic [31:0] ram [logic [31:0]];
    int          starve;
    bit          if_first;
    int          pend;       // 0 none, 1 fetch, 2 load
    logic [31:0] pend_val, last_if, last_d;
    bit          e_if, e_d;
    logic        o_if_gnt, o_d_gnt, o_if_rv, o_d_rv, o_stall, o_mwe;
    logic [31:0] o_if_rd, o_d_rd, o_maddr, o_mwd;

    function automatic logic [31:0] ram_rd(logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return {a[15:0], 16'h5A00};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(string tag);
        bit          e_en, e_we, e_stall, e_irv, e_drv;
        logic [31:0] e_addr, e_wd, e_ird, e_drd;
        @(negedge clk);
        e_if = 0;
        e_d  = 0;
        if (!x_reset) begin
            if (bus.if_req && bus.d_req) begin
`ifdef RISCV_MEM_ARB_RR_EN
                if (if_first) e_if = 1; else e_d = 1;
`else
                if (starve >= MS) e_if = 1; else e_d = 1;
`endif
            end else begin
                e_if = bus.if_req;
                e_d  = bus.d_req;
            end
        end
        e_en    = e_if | e_d;
        e_we    = e_d & bus.d_we;
        e_addr  = e_if ? bus.if_addr : (e_d ? bus.d_addr : 32'd0);
        e_wd    = e_d ? bus.d_wdata : 32'd0;
        e_stall = !x_reset && bus.if_req && !e_if;
        e_irv   = !x_reset && pend == 1;
        e_drv   = !x_reset && pend == 2;
        e_ird   = x_reset ? 32'd0 : (e_irv ? pend_val : last_if);
        e_drd   = x_reset ? 32'd0 : (e_drv ? pend_val : last_d);

        o_if_gnt = bus.if_gnt;   o_d_gnt = bus.d_gnt;
        o_if_rv  = bus.if_rvalid; o_d_rv = bus.d_rvalid;
        o_if_rd  = bus.if_rdata;  o_d_rd = bus.d_rdata;
        o_stall  = bus.if_stall;  o_maddr = bus.mem_addr;
        o_mwe    = bus.mem_we;    o_mwd = bus.mem_wdata;

        chk({tag, ".if_gnt"},    bus.if_gnt,    e_if);
        chk({tag, ".d_gnt"},     bus.d_gnt,     e_d);
        chk({tag, ".mem_en"},    bus.mem_en,    e_en);
        chk({tag, ".mem_we"},    bus.mem_we,    e_we);
        chk({tag, ".mem_addr"},  bus.mem_addr,  e_addr);
        chk({tag, ".mem_wdata"}, bus.mem_wdata, e_wd);
        chk({tag, ".if_stall"},  bus.if_stall,  e_stall);
        chk({tag, ".if_rvalid"}, bus.if_rvalid, e_irv);
        chk({tag, ".d_rvalid"},  bus.d_rvalid,  e_drv);
        chk({tag, ".if_rdata"},  bus.if_rdata,  e_ird);
        chk({tag, ".d_rdata"},   bus.d_rdata,   e_drd);

        @(posedge clk);
        if (x_reset) begin
            starve = 0; if_first = 0; pend = 0; last_if = 0; last_d = 0;
        end else begin
            if (pend == 1) last_if = pend_val;
            if (pend == 2) last_d = pend_val;
            if (e_if) starve = 0;
            else if (bus.if_req && starve < MS) starve++;
            if (bus.if_req && bus.d_req) if_first = e_d;
            pend = 0;
            if (e_if) begin
                pend = 1; pend_val = ram_rd(bus.if_addr);
            end else if (e_d && !bus.d_we) begin
                pend = 2; pend_val = ram_rd(bus.d_addr);
            end else if (e_d) begin
                ram[bus.d_addr] = bus.d_wdata;
            end
        end
        #1;
        bus.mem_rdata = (pend != 0) ? pend_val : $urandom();
    endtask

    initial begin
        logic [9:0] pat;
        logic [9:0] pat_exp;
        starve = 0; if_first = 0; pend = 0; pend_val = 0; last_if = 0; last_d = 0;
        x_reset = 1;
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0;

        step("rst0");
        bus.if_req = 1; bus.if_addr = 32'h100;
        step("rst_req");
        x_reset = 0; bus.if_req = 0;
        step("idle");

        // Fetch only.
        ram[32'h100] = 32'h0000_0013;
        bus.if_req = 1; bus.if_addr = 32'h100;
        step("fetch");
        chk("fetch.gnt_now", o_if_gnt, 1'b1);
        bus.if_req = 0;
        step("fetch_rsp");
        chk("fetch.rvalid", o_if_rv, 1'b1);
        chk("fetch.rdata", o_if_rd, 32'h13);

        // Contention, data wins.
        ram[32'h200] = 32'h2222_0200;
        bus.if_req = 1; bus.if_addr = 32'h104;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
        step("cont");
        chk("cont.d_gnt", o_d_gnt, 1'b1);
        chk("cont.stall", o_stall, 1'b1);
        chk("cont.maddr", o_maddr, 32'h200);
        bus.d_req = 0;
        step("cont2");
        chk("cont2.d_rvalid", o_d_rv, 1'b1);
        chk("cont2.if_gnt", o_if_gnt, 1'b1);
        bus.if_req = 0;
        step("cont3");

        // Both held: starvation (or alternation) pattern, observed fetch grants per cycle.
        x_reset = 1;
        step("rst1");
        x_reset = 0;
        bus.if_req = 1; bus.if_addr = 32'h180;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h210;
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            step("hold");
            pat = {pat[8:0], o_if_gnt};
        end
`ifdef RISCV_MEM_ARB_RR_EN
        pat_exp = 10'b01_0101_0101;
`else
        pat_exp = 10'b00_0010_0001;
`endif
        chk("hold.pattern", pat, pat_exp);
        bus.if_req = 0; bus.d_req = 0;
        step("drain");

        // Store then read back.
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF;
        step("store");
        chk("store.mem_we", o_mwe, 1'b1);
        chk("store.wdata", o_mwd, 32'hDEAD_BEEF);
        bus.d_req = 0; bus.d_we = 0;
        step("store_after");
        chk("store.no_rvalid", o_d_rv, 1'b0);
        bus.d_req = 1;
        step("load40");
        bus.d_req = 0;
        step("load40_rsp");
        chk("load40.rdata", o_d_rd, 32'hDEAD_BEEF);

        // Reset in the response cycle of a fetch.
        bus.if_req = 1; bus.if_addr = 32'h100;
        step("rmid_gnt");
        bus.if_req = 0; x_reset = 1;
        step("rmid_rst");
        chk("rmid.rvalid_in_rst", o_if_rv, 1'b0);
        x_reset = 0;
        step("rmid_after");
        chk("rmid.rvalid_after", o_if_rv, 1'b0);
        chk("rmid.rdata_after", o_if_rd, 32'd0);

        // Random traffic; requests are held until the model says they were granted.
        for (int i = 0; i < 400; i++) begin
            x_reset = ($urandom_range(0, 39) == 0);
            if (!(bus.if_req && !e_if)) begin
                bus.if_req  = $urandom_range(0, 1);
                bus.if_addr = 32'h1000 + 4 * $urandom_range(0, 15);
            end
            if (!(bus.d_req && !e_d)) begin
                bus.d_req   = $urandom_range(0, 1);
                bus.d_we    = $urandom_range(0, 1);
                bus.d_addr  = 32'h300 + 4 * $urandom_range(0, 7);
                bus.d_wdata = $urandom();
            end
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
